// File: rtl/perf_mmio_pkg.sv
// perf_mmio_pkg: shared state encoding, register map, bit positions and BCD helper for perf_mmio.
package perf_mmio_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;
  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_CYCLES  = 3'd2;
  localparam logic [2:0] OFF_DISPLAY = 3'd3;
  localparam logic [2:0] OFF_COMPARE = 3'd4;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;
  localparam int CTRL_SHOW  = 3;
  localparam int STAT_OVF  = 2;
  localparam int STAT_TMO  = 3;
  localparam int STAT_BUSY = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [23:0] bcd_adj(input logic [23:0] a);
    logic [23:0] r;
    r = a;
    for (int i = 0; i < 6; i++)
      r[i*4 +: 4] = (r[i*4 +: 4] >= 4'd5) ? r[i*4 +: 4] + 4'd3 : r[i*4 +: 4];
    return r;
  endfunction
endpackage

// File: rtl/perf_bcd_conv.sv
// perf_bcd_conv: 32-step shift-add-3 converter keeping only the low six BCD digits (value mod 10^6).
module perf_bcd_conv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);
  import perf_mmio_pkg::*;
  logic [31:0] bin;
  logic [23:0] adj;
  logic [4:0]  cnt;
  assign adj = bcd_adj(bcd);
  // Lower digits never depend on higher ones, so dropping digits above six yields value mod 10^6.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (busy) begin
        bcd <= {adj[22:0], bin[31]};
        bin <= {bin[30:0], 1'b0};
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        busy <= 1'b1;
        bin  <= value;
        bcd  <= '0;
        cnt  <= '0;
      end
    end
endmodule

// File: rtl/perf_mmio.sv
// perf_mmio: memory-mapped cycle counter with ebreak halt and BCD display.
// Define PERF_MMIO_TIMEOUT_EN to add the COMPARE timeout halt.
module perf_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] instr,
  output logic [31:0] rdata,
  output logic        sel,
  output logic [23:0] digits,
  output logic        halted
);
  import perf_mmio_pkg::*;
  state_t      state, state_nx;
  logic [31:0] cycles, compare;
  logic [23:0] display, cyc_digits, conv_bcd;
  logic [2:0]  off;
  logic        show, ovf, tmo, run;
  logic        wr, wr_ctrl, start, stop, clr, cyc_wr, inc, wrap, tmo_hit;
  logic        conv_busy, conv_done;
  logic        unused_addr;
  assign unused_addr = ^addr[1:0];
  assign sel     = addr[31:5] == BASE_ADDR[31:5];
  assign off     = addr[4:2];
  assign wr      = we && sel;
  assign wr_ctrl = wr && off == OFF_CTRL;
  assign start   = wr_ctrl && wdata[CTRL_START];
  assign stop    = wr_ctrl && wdata[CTRL_STOP];
  assign clr     = wr_ctrl && wdata[CTRL_CLEAR];
  assign cyc_wr  = wr && off == OFF_CYCLES;
  assign inc     = run && !clr && !cyc_wr;
  assign wrap    = inc && &cycles;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_nx;
  // Stop outranks everything; a halt request in RUN outranks a redundant start.
  always_comb
    state_nx = stop ? ST_IDLE
             : (run && (instr == EBREAK || tmo_hit)) ? ST_HALTED
             : start ? ST_RUN
             : state;
  always_comb begin
    run    = state == ST_RUN;
    halted = state == ST_HALTED;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cycles     <= '0;
      ovf        <= 1'b0;
      show       <= 1'b0;
      display    <= '0;
      cyc_digits <= '0;
    end else begin
      cycles <= clr ? '0 : cyc_wr ? wdata : inc ? cycles + 32'd1 : cycles;
      ovf    <= clr ? 1'b0 : ovf | wrap;
      if (wr_ctrl) show <= wdata[CTRL_SHOW];
      if (wr && off == OFF_DISPLAY) display <= wdata[23:0];
      if (conv_done && show) cyc_digits <= conv_bcd;
    end
`ifdef PERF_MMIO_TIMEOUT_EN
  assign tmo_hit = inc && !stop && compare != '0 && cycles + 32'd1 == compare;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      compare <= '0;
      tmo     <= 1'b0;
    end else begin
      if (wr && off == OFF_COMPARE) compare <= wdata;
      tmo <= clr ? 1'b0 : tmo | tmo_hit;
    end
`else
  assign tmo_hit = 1'b0;
  assign compare = '0;
  assign tmo     = 1'b0;
`endif
  perf_bcd_conv u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (show && !conv_busy),
    .abort   (!show),
    .value   (cycles),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );
  assign digits = show ? cyc_digits : display;
  always_comb
    rdata = !sel ? '0
          : off == OFF_CTRL    ? {28'd0, show, 3'd0}
          : off == OFF_STATUS  ? {27'd0, conv_busy, tmo, ovf, state}
          : off == OFF_CYCLES  ? cycles
          : off == OFF_DISPLAY ? {8'd0, display}
          : off == OFF_COMPARE ? compare
          : '0;
endmodule

// File: tb/tb_perf_mmio.sv
// tb_perf_mmio: randomized and directed checks of perf_mmio against a register-level reference model.
module tb_perf_mmio;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0, instr = '0, rdata;
  logic        we = 1'b0, sel, halted;
  logic [23:0] digits;
  int checks = 0, errors = 0;
  logic [1:0]  m_state;
  logic [31:0] m_cyc, m_cmp;
  logic [23:0] m_disp;
  logic        m_ovf, m_tmo, m_show;
  perf_mmio #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .instr   (instr),
    .rdata   (rdata),
    .sel     (sel),
    .digits  (digits),
    .halted  (halted)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] to_bcd(input logic [31:0] v);
    int unsigned r;
    logic [23:0] o;
    r = v % 1000000;
    for (int k = 0; k < 6; k++) begin
      o[k*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return o;
  endfunction
  function automatic logic is_bcd(input logic [23:0] x);
    for (int k = 0; k < 6; k++) if (x[k*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction
  task automatic m_reset();
    m_state = 2'd0; m_cyc = '0; m_cmp = '0; m_disp = '0;
    m_ovf = 1'b0; m_tmo = 1'b0; m_show = 1'b0;
  endtask
  // One clock: drive the bus, then advance the model by the register-map rules.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [31:0] i);
    logic s, stp, sta, clr, cw, run, hit;
    logic [2:0] o;
    addr = a; wdata = d; we = w; instr = i;
    @(posedge clk);
    s = w && a[31:5] == BASE[31:5];
    o = a[4:2];
    stp = s && o == 3'd0 && d[1];
    sta = s && o == 3'd0 && d[0];
    clr = s && o == 3'd0 && d[2];
    cw  = s && o == 3'd2;
    run = m_state == 2'd1;
    hit = 1'b0;
`ifdef PERF_MMIO_TIMEOUT_EN
    hit = run && !clr && !cw && !stp && m_cmp != 0 && m_cyc + 32'd1 == m_cmp;
    if (clr) m_tmo = 1'b0; else if (hit) m_tmo = 1'b1;
    if (s && o == 3'd4) m_cmp = d;
`endif
    if (clr) m_ovf = 1'b0;
    else if (run && !cw && m_cyc == 32'hFFFF_FFFF) m_ovf = 1'b1;
    m_cyc = clr ? 32'd0 : cw ? d : run ? m_cyc + 32'd1 : m_cyc;
    if (stp) m_state = 2'd0;
    else if (run && (i == EBRK || hit)) m_state = 2'd2;
    else if (sta) m_state = 2'd1;
    if (s && o == 3'd0) m_show = d[3];
    if (s && o == 3'd3) m_disp = d[23:0];
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'h0, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    step(BASE + {27'd0, o, 2'b00}, d, 1'b1, 32'h0);
  endtask
  task automatic rd(input logic [2:0] o, output logic [31:0] v);
    addr = BASE + {27'd0, o, 2'b00};
    we = 1'b0;
    #1;
    v = rdata;
  endtask
  task automatic check_all(input string tag);
    logic [31:0] v;
    rd(3'd1, v); check({tag, ".status"}, v & 32'hFFFF_FFEF, {28'd0, m_tmo, m_ovf, m_state});
    rd(3'd2, v); check({tag, ".cycles"}, v, m_cyc);
    rd(3'd0, v); check({tag, ".ctrl"}, v, {28'd0, m_show, 3'd0});
    rd(3'd3, v); check({tag, ".display"}, v, {8'd0, m_disp});
    rd(3'd4, v); check({tag, ".compare"}, v, m_cmp);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_state == 2'd2});
    if (m_show) check({tag, ".bcd_ok"}, {31'd0, is_bcd(digits)}, 32'd1);
    else check({tag, ".digits"}, {8'd0, digits}, {8'd0, m_disp});
  endtask
  task automatic wait_digits(input string tag, input logic [23:0] exp);
    logic [31:0] v;
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && digits !== exp; k++) begin
      rd(3'd1, v);
      seen |= v[4];
      idle(1);
    end
    check({tag, ".digits"}, {8'd0, digits}, {8'd0, exp});
    check({tag, ".busy_seen"}, {31'd0, seen}, 32'd1);
  endtask
  initial begin
    logic [31:0] v;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_all("reset");
    addr = BASE + 32'd32; #1;
    check("unsel_rdata", rdata, 32'd0);
    check("unsel_sel", {31'd0, sel}, 32'd0);
    wr(3'd0, 32'd1); idle(99); wr(3'd0, 32'd2);
    rd(3'd2, v); check("run100", v, 32'd100);
    check_all("run100");
    wr(3'd0, 32'd3);
    check_all("startstop");
    wr(3'd0, 32'd1); idle(5); step(32'h0, 32'h0, 1'b0, EBRK);
    check_all("ebreak");
    idle(4);
    check_all("frozen");
    wr(3'd2, 32'hFFFF_FFFE); wr(3'd0, 32'd1); idle(3);
    rd(3'd2, v); check("wrap_cyc", v, 32'd1);
    rd(3'd1, v); check("wrap_ovf", {31'd0, v[2]}, 32'd1);
    wr(3'd0, 32'd4);
    rd(3'd2, v); check("clr_cyc", v, 32'd0);
    rd(3'd1, v); check("clr_ovf", {31'd0, v[2]}, 32'd0);
    check_all("clear");
    wr(3'd0, 32'd2); wr(3'd2, 32'd1234567); wr(3'd0, 32'd8);
    wait_digits("bcd1234567", 24'h234567);
    wr(3'd2, 32'd999); idle(10); wr(3'd3, 32'h00AB_1234);
    wr(3'd0, 32'd0);
    check("abort_digits", {8'd0, digits}, 32'h0012_1234 + 32'h0099_0000);
    idle(1);
    rd(3'd1, v); check("abort_busy", {31'd0, v[4]}, 32'd0);
    wr(3'd2, 32'hFFFF_FFFF); wr(3'd0, 32'd8);
    wait_digits("bcdmax", to_bcd(32'hFFFF_FFFF));
    wr(3'd0, 32'd0);
`ifdef PERF_MMIO_TIMEOUT_EN
    wr(3'd4, 32'd50); wr(3'd2, 32'd0); wr(3'd0, 32'd1); idle(49);
    rd(3'd1, v); check("tmo_before", v & 32'hF, 32'd1);
    idle(1);
    rd(3'd1, v); check("tmo_hit", v & 32'hF, 32'hA);
    rd(3'd2, v); check("tmo_cyc", v, 32'd50);
    check_all("tmo");
    wr(3'd0, 32'd6); wr(3'd4, 32'd0);
`else
    wr(3'd4, 32'd50);
    rd(3'd4, v); check("cmp_ro", v, 32'd0);
    wr(3'd2, 32'd0); wr(3'd0, 32'd1); idle(60);
    rd(3'd1, v); check("no_tmo", v & 32'hF, 32'd1);
    check_all("no_tmo");
    wr(3'd0, 32'd2);
`endif
    wr(3'd0, 32'd9); idle(10);
    rd(3'd1, v); check("mid_busy", {31'd0, v[4]}, 32'd1);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    check("rst_digits", {8'd0, digits}, 32'd0);
    rd(3'd1, v); check("rst_status", v, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check_all("post_reset");
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 2) wr(3'd0, 32'($urandom_range(0, 15)));
      else if (r == 2) wr(3'd2, $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      else if (r == 3) wr(3'd3, $urandom);
      else if (r == 4) wr(3'd4, 32'($urandom_range(0, 80)));
      else if (r == 5) wr(3'($urandom_range(5, 7)), $urandom);
      else if (r == 6) step(32'h0000_0800 | 32'($urandom_range(0, 31)), $urandom, 1'b1, 32'h0);
      else if (r == 7) step(32'h0, 32'h0, 1'b0, EBRK);
      else step(32'h0, 32'h0, 1'b0, $urandom);
      check_all("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
